// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// The sequencer drives the master side; the datapath/memory is the slave.
interface multicycle_control_fsm_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         op_code;
  logic               mem_ready;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic [1:0]         MemtoReg;
  logic [1:0]         RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         PCSource;
  logic               instr_done;
  logic               illegal_op;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op_code, mem_ready,
    output PCWrite, PCWriteCond, IorD,
    output MemRead, MemWrite, IRWrite,
    output MemtoReg, RegDst, RegWrite,
    output ALUSrcA, ALUSrcB, ALUOp, PCSource,
    output instr_done, illegal_op, state_o
  );

  modport slave (
    output op_code, mem_ready,
    input  PCWrite, PCWriteCond, IorD,
    input  MemRead, MemWrite, IRWrite,
    input  MemtoReg, RegDst, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUOp, PCSource,
    input  instr_done, illegal_op, state_o
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with optional
// memory wait states; R, addi, andi, lw, sw, beq, jal; others halt.
module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int STATE_W       = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  multicycle_control_fsm_if.master bus
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_JAL  = 6'h03;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = STATE_W'(0),
    S_DECODE  = STATE_W'(1),
    S_MEMADR  = STATE_W'(2),
    S_MEMRD   = STATE_W'(3),
    S_MEMWB   = STATE_W'(4),
    S_MEMWR   = STATE_W'(5),
    S_REXEC   = STATE_W'(6),
    S_RWB     = STATE_W'(7),
    S_BRANCH  = STATE_W'(8),
    S_JAL     = STATE_W'(9),
    S_IEXEC   = STATE_W'(10),
    S_IWB     = STATE_W'(11),
    S_ILLEGAL = STATE_W'(12)
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_o;
  logic   rdy;

  assign rdy = bus.mem_ready | ~MEM_HANDSHAKE;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = rdy;
        ctrl.pc_write  = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        case (bus.op_code)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_R:             state_d = S_REXEC;
          OP_ADDI, OP_ANDI: state_d = S_IEXEC;
          OP_BEQ:           state_d = S_BRANCH;
          OP_JAL:           state_d = S_JAL;
          default:          state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d = (bus.op_code == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 2'b01;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = rdy;
        if (rdy) state_d = S_FETCH;
      end
      S_REXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        ctrl.reg_dst    = 2'b01;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        ctrl.instr_done    = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = 2'b10;
        ctrl.reg_dst    = 2'b10;
        ctrl.mem_to_reg = 2'b10;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = (bus.op_code == OP_ANDI) ? 2'b11 : 2'b00;
        state_d = S_IWB;
      end
      S_IWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: begin
        ctrl.illegal_op = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs forced low during reset so no write escapes mid-instruction
  assign ctrl_o = reset_n ? ctrl : '0;

  assign bus.PCWrite     = ctrl_o.pc_write;
  assign bus.PCWriteCond = ctrl_o.pc_write_cond;
  assign bus.IorD        = ctrl_o.iord;
  assign bus.MemRead     = ctrl_o.mem_read;
  assign bus.MemWrite    = ctrl_o.mem_write;
  assign bus.IRWrite     = ctrl_o.ir_write;
  assign bus.MemtoReg    = ctrl_o.mem_to_reg;
  assign bus.RegDst      = ctrl_o.reg_dst;
  assign bus.RegWrite    = ctrl_o.reg_write;
  assign bus.ALUSrcA     = ctrl_o.alu_src_a;
  assign bus.ALUSrcB     = ctrl_o.alu_src_b;
  assign bus.ALUOp       = ctrl_o.alu_op;
  assign bus.PCSource    = ctrl_o.pc_source;
  assign bus.instr_done  = ctrl_o.instr_done;
  assign bus.illegal_op  = ctrl_o.illegal_op;
  assign bus.state_o     = reset_n ? state_q : '0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: stimulus queues per-cycle expected control vectors,
// a negedge monitor pops and compares them against the selected DUT.
module tb_multicycle_control_fsm;

  logic clk;
  logic rst0_n, rst1_n;

  multicycle_control_fsm_if #(.STATE_W(4)) b0 ();
  multicycle_control_fsm_if #(.STATE_W(4)) b1 ();

  multicycle_control_fsm #(
    .MEM_HANDSHAKE(1'b1), .STATE_W(4)
  ) dut0 (
    .clk(clk), .reset_n(rst0_n), .bus(b0)
  );

  multicycle_control_fsm #(
    .MEM_HANDSHAKE(1'b0), .STATE_W(4)
  ) dut1 (
    .clk(clk), .reset_n(rst1_n), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] act0, act1;
  assign act0 = {b0.state_o, b0.PCWrite, b0.PCWriteCond,
    b0.IorD, b0.MemRead, b0.MemWrite, b0.IRWrite,
    b0.MemtoReg, b0.RegDst, b0.RegWrite, b0.ALUSrcA,
    b0.ALUSrcB, b0.ALUOp, b0.PCSource,
    b0.instr_done, b0.illegal_op};
  assign act1 = {b1.state_o, b1.PCWrite, b1.PCWriteCond,
    b1.IorD, b1.MemRead, b1.MemWrite, b1.IRWrite,
    b1.MemtoReg, b1.RegDst, b1.RegWrite, b1.ALUSrcA,
    b1.ALUSrcB, b1.ALUOp, b1.PCSource,
    b1.instr_done, b1.illegal_op};

  typedef struct packed {
    bit          dut;
    int          tag;
    logic [23:0] v;
  } sb_t;

  sb_t q[$];
  int  checks = 0;
  int  passed = 0;

  // Expected outputs for a state, straight from the control table
  function automatic logic [23:0] exp_vec(
    input int st, input logic [5:0] op,
    input bit rdy, input bit rstn
  );
    logic pw, pwc, iord, mr, mw, irw, rw, asa, done, ill;
    logic [1:0] m2r, rd, asb, aop, psrc;
    {pw, pwc, iord, mr, mw, irw, rw, asa, done, ill} = '0;
    {m2r, rd, asb, aop, psrc} = '0;
    case (st)
      0: begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      1: asb = 2'b11;
      2: begin asa = 1; asb = 2'b10; end
      3: begin mr = 1; iord = 1; end
      4: begin m2r = 2'b01; rw = 1; done = 1; end
      5: begin mw = 1; iord = 1; done = rdy; end
      6: begin asa = 1; aop = 2'b10; end
      7: begin rd = 2'b01; rw = 1; done = 1; end
      8: begin
        asa = 1; aop = 2'b01; pwc = 1;
        psrc = 2'b01; done = 1;
      end
      9: begin
        pw = 1; psrc = 2'b10; rd = 2'b10;
        m2r = 2'b10; rw = 1; done = 1;
      end
      10: begin
        asa = 1; asb = 2'b10;
        aop = (op == 6'h0C) ? 2'b11 : 2'b00;
      end
      11: begin rw = 1; done = 1; end
      12: ill = 1;
      default: ;
    endcase
    if (!rstn) return '0;
    return {4'(st), pw, pwc, iord, mr, mw, irw,
      m2r, rd, rw, asa, asb, aop, psrc, done, ill};
  endfunction

  task automatic cyc(
    input int d, input int t, input logic [5:0] op,
    input bit rdy, input bit rstn, input int st
  );
    sb_t e;
    @(posedge clk);
    #1;
    if (d == 0) begin
      b0.op_code   = op;
      b0.mem_ready = rdy;
      rst0_n = rstn;
      rst1_n = 1'b0;
    end else begin
      b1.op_code = op;
      rst1_n = rstn;
      rst0_n = 1'b0;
    end
    e.dut = d[0];
    e.tag = t;
    e.v   = exp_vec(st, op, (d == 1) ? 1'b1 : rdy, rstn);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    sb_t e;
    logic [23:0] a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = e.dut ? act1 : act0;
      checks++;
      if (a === e.v) passed++;
      else $display("FAIL t%0d dut%0d ctrl got=%h exp=%h (state got=%0d exp=%0d)",
        e.tag, e.dut, a, e.v, a[23:20], e.v[23:20]);
    end
  end

  initial begin
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    b0.op_code = 6'h00;
    b0.mem_ready = 1'b0;
    b1.op_code = 6'h00;
    b1.mem_ready = 1'b0;

    // reset
    cyc(0, 0, 6'h00, 1, 0, 0);
    cyc(0, 0, 6'h00, 1, 0, 0);
    // R-type; op garbage outside DECODE is ignored
    cyc(0, 1, 6'h3F, 1, 1, 0);
    cyc(0, 1, 6'h00, 1, 1, 1);
    cyc(0, 1, 6'h3F, 1, 1, 6);
    cyc(0, 1, 6'h23, 1, 1, 7);
    // lw with two wait cycles in MEMRD
    cyc(0, 2, 6'h23, 1, 1, 0);
    cyc(0, 2, 6'h23, 1, 1, 1);
    cyc(0, 2, 6'h23, 1, 1, 2);
    cyc(0, 2, 6'h23, 0, 1, 3);
    cyc(0, 2, 6'h23, 0, 1, 3);
    cyc(0, 2, 6'h23, 1, 1, 3);
    cyc(0, 2, 6'h23, 1, 1, 4);
    // FETCH wait states
    for (int i = 0; i < 3; i++) cyc(0, 3, 6'h00, 0, 1, 0);
    cyc(0, 3, 6'h00, 1, 1, 0);
    cyc(0, 3, 6'h00, 1, 1, 1);
    cyc(0, 3, 6'h00, 1, 1, 6);
    cyc(0, 3, 6'h00, 1, 1, 7);
    // sw, beq, jal
    cyc(0, 4, 6'h2B, 1, 1, 0);
    cyc(0, 4, 6'h2B, 1, 1, 1);
    cyc(0, 4, 6'h2B, 1, 1, 2);
    cyc(0, 4, 6'h2B, 1, 1, 5);
    cyc(0, 4, 6'h04, 1, 1, 0);
    cyc(0, 4, 6'h04, 1, 1, 1);
    cyc(0, 4, 6'h04, 1, 1, 8);
    cyc(0, 4, 6'h03, 1, 1, 0);
    cyc(0, 4, 6'h03, 1, 1, 1);
    cyc(0, 4, 6'h03, 1, 1, 9);
    // andi, addi, illegal
    cyc(0, 5, 6'h0C, 1, 1, 0);
    cyc(0, 5, 6'h0C, 1, 1, 1);
    cyc(0, 5, 6'h0C, 1, 1, 10);
    cyc(0, 5, 6'h0C, 1, 1, 11);
    cyc(0, 5, 6'h08, 1, 1, 0);
    cyc(0, 5, 6'h08, 1, 1, 1);
    cyc(0, 5, 6'h08, 1, 1, 10);
    cyc(0, 5, 6'h08, 1, 1, 11);
    cyc(0, 5, 6'h3F, 1, 1, 0);
    cyc(0, 5, 6'h3F, 1, 1, 1);
    for (int i = 0; i < 20; i++)
      cyc(0, 5, (i[0] ? 6'h23 : 6'h3F), i[1], 1, 12);
    // reset in ILLEGAL, then reset in MEMWR
    cyc(0, 6, 6'h3F, 1, 0, 12);
    cyc(0, 6, 6'h2B, 1, 1, 0);
    cyc(0, 6, 6'h2B, 1, 1, 1);
    cyc(0, 6, 6'h2B, 1, 1, 2);
    cyc(0, 6, 6'h2B, 0, 1, 5);
    cyc(0, 6, 6'h2B, 0, 0, 5);
    cyc(0, 6, 6'h2B, 1, 1, 0);
    // MEM_HANDSHAKE=0, mem_ready tied low: lw in 5 cycles
    cyc(1, 7, 6'h23, 0, 0, 0);
    cyc(1, 7, 6'h23, 0, 1, 0);
    cyc(1, 7, 6'h23, 0, 1, 1);
    cyc(1, 7, 6'h23, 0, 1, 2);
    cyc(1, 7, 6'h23, 0, 1, 3);
    cyc(1, 7, 6'h23, 0, 1, 4);
    cyc(1, 7, 6'h23, 0, 1, 0);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain queue left=%0d required=0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
